// File: rtl/pe_pkg.sv
// Shared constants for the motion-estimation PE.
// Reference mux encoding, FSM states and the default pixel width.
package pe_pkg;
  localparam int PIXEL_W_DEF = 8;

  localparam logic [1:0] REF_UP_1 = 2'd0;
  localparam logic [1:0] REF_UP_8 = 2'd1;
  localparam logic [1:0] REF_DN_1 = 2'd2;
  localparam logic [1:0] REF_DN_8 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_t;
endpackage

// File: rtl/pe_sad_acc_if.sv
// SAD accumulate handshake between the ME controller and one PE.
// master drives start/valid, slave (the PE) returns the result.
interface pe_sad_acc_if
  import pe_pkg::*;
#(
  parameter int ACC_W = 16
);
  logic             acc_start;
  logic             acc_valid;
  logic [ACC_W-1:0] sad_out;
  logic             sad_valid;
  logic             busy;

  modport master (
    output acc_start, acc_valid,
    input  sad_out, sad_valid, busy
  );

  modport slave (
    input  acc_start, acc_valid,
    output sad_out, sad_valid, busy
  );
endinterface

// File: rtl/pe_absdiff.sv
// Combinational unsigned |a - b|, shared across the PE array.
module pe_absdiff
  import pe_pkg::*;
#(
  parameter int W = PIXEL_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = (a > b) ? (a - b) : (b - a);
endmodule

// File: rtl/pe_sad_acc.sv
// ME processing element with CB bank, ref mux and SAD accumulator.
// `define PE_BEST_TRACK_EN adds best-candidate tracking.
module pe_sad_acc
  import pe_pkg::*;
#(
  parameter int PIXEL_W    = PIXEL_W_DEF,
  parameter int NUM_CB     = 4,
  parameter int CB_SEL_W   = 4,
  parameter int BLK_PIXELS = 64,
  parameter int ACC_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PIXEL_W-1:0]  in_curr,
  input  logic                in_curr_en,
  input  logic [CB_SEL_W-1:0] cb_wr_sel,
  input  logic [CB_SEL_W-1:0] cb_rd_sel,
  input  logic [PIXEL_W-1:0]  ref_up_1,
  input  logic [PIXEL_W-1:0]  ref_up_8,
  input  logic [PIXEL_W-1:0]  ref_dn_1,
  input  logic [PIXEL_W-1:0]  ref_dn_8,
  input  logic                ref_en,
  input  logic [1:0]          ref_sel,
  output logic [PIXEL_W-1:0]  next_pix,
  output logic [PIXEL_W-1:0]  ref_pix,
  output logic [PIXEL_W-1:0]  abs_out,
`ifdef PE_BEST_TRACK_EN
  input  logic                best_clr,
  output logic [ACC_W-1:0]    best_sad,
  output logic [7:0]          best_idx,
`endif
  pe_sad_acc_if.slave         acc
);
  localparam int CNT_W = $clog2(BLK_PIXELS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLK_PIXELS);

  logic [PIXEL_W-1:0] cb_q [NUM_CB];
  logic [PIXEL_W-1:0] rd_pix;
  logic [PIXEL_W-1:0] fwd_pix;
  logic [PIXEL_W-1:0] ref_mux;
  logic [PIXEL_W-1:0] diff;
  state_t             state;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic               v_q;

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_pix  = '0;
    fwd_pix = '0;
    for (int i = 0; i < NUM_CB; i++) begin
      if (cb_rd_sel == CB_SEL_W'(i)) rd_pix = cb_q[i];
      if (cb_wr_sel == CB_SEL_W'(i)) fwd_pix = cb_q[i];
    end
  end

  assign next_pix = fwd_pix;

  always_comb begin
    ref_mux = ref_up_1;
    unique case (ref_sel)
      REF_UP_1: ref_mux = ref_up_1;
      REF_UP_8: ref_mux = ref_up_8;
      REF_DN_1: ref_mux = ref_dn_1;
      REF_DN_8: ref_mux = ref_dn_8;
    endcase
  end

  pe_absdiff #(.W(PIXEL_W)) u_absdiff (
    .a (rd_pix),
    .b (ref_pix),
    .y (diff)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CB; i++) cb_q[i] <= '0;
      ref_pix <= '0;
      abs_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CB; i++)
        if (in_curr_en && cb_wr_sel == CB_SEL_W'(i))
          cb_q[i] <= in_curr;
      if (ref_en) ref_pix <= ref_mux;
      abs_out <= diff;
    end
  end

  // The full count waits one cycle so the last sample lands before FLUSH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      v_q           <= 1'b0;
      acc.sad_out   <= '0;
      acc.sad_valid <= 1'b0;
    end else begin
      acc.sad_valid <= 1'b0;
      v_q           <= 1'b0;
      if (v_q) acc_q <= acc_q + ACC_W'(abs_out);
      unique case (state)
        IDLE: begin
          if (acc.acc_start) begin
            acc_q <= '0;
            cnt_q <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (acc.acc_start) begin
            acc_q <= '0;
            cnt_q <= '0;
          end else if (cnt_q == CNT_FULL) begin
            state <= FLUSH;
          end else if (acc.acc_valid) begin
            cnt_q <= cnt_q + 1'b1;
            v_q   <= 1'b1;
          end
        end
        FLUSH: begin
          acc.sad_out   <= acc_q;
          acc.sad_valid <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign acc.busy = (state == ACCUM) || (state == FLUSH);

`ifdef PE_BEST_TRACK_EN
  logic [7:0] cand_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_sad <= '1;
      best_idx <= '0;
      cand_q   <= '0;
    end else if (best_clr) begin
      best_sad <= '1;
      best_idx <= '0;
      cand_q   <= '0;
    end else if (state == FLUSH) begin
      if (acc_q < best_sad) begin
        best_sad <= acc_q;
        best_idx <= cand_q;
      end
      cand_q <= cand_q + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pe_sad_acc.sv
// Scoreboard bench for pe_sad_acc: directed vectors, queued SAD checks.
// Build with +define+PE_BEST_TRACK_EN to also cover best tracking.
module tb_pe_sad_acc;
  import pe_pkg::*;

  localparam int PW  = 8;
  localparam int NCB = 4;
  localparam int SW  = 4;
  localparam int BLK = 64;
  localparam int AW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] in_curr;
  logic          in_curr_en;
  logic [SW-1:0] cb_wr_sel;
  logic [SW-1:0] cb_rd_sel;
  logic [PW-1:0] ref_up_1, ref_up_8, ref_dn_1, ref_dn_8;
  logic          ref_en;
  logic [1:0]    ref_sel;
  logic [PW-1:0] next_pix, ref_pix, abs_out;
  logic          best_clr;
`ifdef PE_BEST_TRACK_EN
  logic [AW-1:0] best_sad;
  logic [7:0]    best_idx;
`endif

  pe_sad_acc_if #(.ACC_W(AW)) acc ();

  pe_sad_acc #(
    .PIXEL_W(PW), .NUM_CB(NCB), .CB_SEL_W(SW),
    .BLK_PIXELS(BLK), .ACC_W(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_curr    (in_curr),
    .in_curr_en (in_curr_en),
    .cb_wr_sel  (cb_wr_sel),
    .cb_rd_sel  (cb_rd_sel),
    .ref_up_1   (ref_up_1),
    .ref_up_8   (ref_up_8),
    .ref_dn_1   (ref_dn_1),
    .ref_dn_8   (ref_dn_8),
    .ref_en     (ref_en),
    .ref_sel    (ref_sel),
    .next_pix   (next_pix),
    .ref_pix    (ref_pix),
    .abs_out    (abs_out),
`ifdef PE_BEST_TRACK_EN
    .best_clr   (best_clr),
    .best_sad   (best_sad),
    .best_idx   (best_idx),
`endif
    .acc        (acc.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] sad;
    int            at;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && acc.sad_valid === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sad_unexpected: got sad %0d at cycle %0d, expected none",
                 acc.sad_out, cyc);
      end else begin
        e = q.pop_front();
        chk("sad_out", 32'(acc.sad_out), 32'(e.sad));
        chk("sad_latency", cyc, e.at);
        chk("busy_drop", 32'(acc.busy), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cb(input int sel, input int val);
    cb_wr_sel  = SW'(sel);
    in_curr    = PW'(val);
    in_curr_en = 1'b1;
    step();
    in_curr_en = 1'b0;
  endtask

  task automatic set_ref(input int val);
    ref_up_1 = PW'(val);
    ref_sel  = REF_UP_1;
    ref_en   = 1'b1;
    step();
    ref_en   = 1'b0;
  endtask

  task automatic setup(input int cb, input int rf);
    wr_cb(0, cb);
    set_ref(rf);
    cb_rd_sel = '0;
    step();
  endtask

  task automatic valids(input int n);
    for (int i = 0; i < n; i++) begin
      acc.acc_valid = 1'b1;
      step();
    end
    acc.acc_valid = 1'b0;
  endtask

  // pre>0 runs a partial SAD and restarts it before the real one.
  task automatic run_sad(input int pre, input int n1, input int gap,
                         input int n2, input int exp, input bit clr);
    exp_t e;
    acc.acc_start = 1'b1;
    step();
    acc.acc_start = 1'b0;
    if (pre > 0) begin
      valids(pre);
      acc.acc_start = 1'b1;
      step();
      acc.acc_start = 1'b0;
    end
    valids(n1);
    repeat (gap) step();
    valids(n2);
    e.sad = AW'(exp);
    e.at  = cyc + 2;
    q.push_back(e);
    step();
    if (clr) best_clr = 1'b1;
    step();
    best_clr = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1;
    in_curr = '0; in_curr_en = 1'b0;
    cb_wr_sel = '0; cb_rd_sel = '0;
    ref_up_1 = '0; ref_up_8 = '0; ref_dn_1 = '0; ref_dn_8 = '0;
    ref_en = 1'b0; ref_sel = '0; best_clr = 1'b0;
    acc.acc_start = 1'b0; acc.acc_valid = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();

    setup(100, 90);
    acc.acc_start = 1'b1;
    step();
    acc.acc_start = 1'b0;
    valids(10);
    chk("busy_mid", 32'(acc.busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_ref_pix", 32'(ref_pix), 0);
    chk("rst_abs_out", 32'(abs_out), 0);
    chk("rst_next_pix", 32'(next_pix), 0);
    chk("rst_sad_out", 32'(acc.sad_out), 0);
    chk("rst_sad_valid", 32'(acc.sad_valid), 0);
    chk("rst_busy", 32'(acc.busy), 0);
`ifdef PE_BEST_TRACK_EN
    chk("rst_best_sad", 32'(best_sad), 32'hFFFF);
    chk("rst_best_idx", 32'(best_idx), 0);
`endif
    step();
    rst = 1'b0;
    repeat (4) step();

    for (int i = 0; i < 4; i++) wr_cb(i, 10 * (i + 1));
    cb_wr_sel = 4'd2;
    #1;
    chk("fwd_cb2", 32'(next_pix), 30);
    wr_cb(7, 99);
    cb_wr_sel = 4'd7;
    #1;
    chk("fwd_oor", 32'(next_pix), 0);
    for (int i = 0; i < 4; i++) begin
      cb_wr_sel = SW'(i);
      #1;
      chk("fwd_bank", 32'(next_pix), 10 * (i + 1));
    end

    ref_up_1 = 8'd1; ref_up_8 = 8'd2; ref_dn_1 = 8'd3; ref_dn_8 = 8'd4;
    for (int s = 0; s < 4; s++) begin
      ref_sel = 2'(s);
      ref_en  = 1'b1;
      step();
      chk("ref_mux", 32'(ref_pix), s + 1);
    end
    ref_en = 1'b0;
    ref_up_1 = 8'd9; ref_up_8 = 8'd9; ref_dn_1 = 8'd9; ref_dn_8 = 8'd9;
    step();
    chk("ref_hold", 32'(ref_pix), 4);

    cb_rd_sel = 4'd5;
    repeat (2) step();
    chk("abs_oor", 32'(abs_out), 4);
    cb_rd_sel = 4'd3;
    repeat (2) step();
    chk("abs_cb3", 32'(abs_out), 36);

    setup(100, 90);
    chk("abs_sample", 32'(abs_out), 10);
    run_sad(0, 64, 0, 0, 640, 1'b0);
    setup(200, 50);
    run_sad(0, 64, 0, 0, 9600, 1'b0);
    setup(100, 90);
    run_sad(0, 32, 5, 32, 640, 1'b0);
    run_sad(10, 64, 0, 0, 640, 1'b0);

`ifdef PE_BEST_TRACK_EN
    best_clr = 1'b1;
    step();
    best_clr = 1'b0;
    run_sad(0, 64, 0, 0, 640, 1'b0);
    setup(100, 95);
    run_sad(0, 64, 0, 0, 320, 1'b0);
    run_sad(0, 64, 0, 0, 320, 1'b0);
    setup(100, 85);
    run_sad(0, 64, 0, 0, 960, 1'b0);
    chk("best_sad", 32'(best_sad), 320);
    chk("best_idx", 32'(best_idx), 1);
    setup(100, 90);
    run_sad(0, 64, 0, 0, 640, 1'b1);
    chk("clr_best_sad", 32'(best_sad), 32'hFFFF);
    chk("clr_best_idx", 32'(best_idx), 0);
    run_sad(0, 64, 0, 0, 640, 1'b0);
    chk("after_clr_sad", 32'(best_sad), 640);
    chk("after_clr_idx", 32'(best_idx), 0);
`endif

    for (int i = 0; i < 50; i++) begin
      if (q.size() == 0) break;
      step();
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
